// File: rtl/axi4_slave_pkg.sv
// Shared types for the AXI4 burst write responder: burst kinds, response codes, FSM states.
package axi4_slave_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_RESP = 2'b10
  } wr_state_e;

endpackage

// File: rtl/axi4_beat_addr_gen.sv
// Window arithmetic for the write responder: start word index, in-window checks, next beat word.
module axi4_beat_addr_gen #(
  parameter int                  AW         = 32,
  parameter int                  SHIFT      = 4,
  parameter logic [AW-1:0]       BASE_ADDR  = 32'hA001_0000,
  parameter logic [AW-1:0]       SPAN_BYTES = 32'h0001_0000
) (
  input  logic [AW-1:0] awaddr_i,
  input  logic [AW-1:0] word_i,
  input  logic          incr_i,
  output logic [AW-1:0] start_word_o,
  output logic          start_in_win_o,
  output logic          word_in_win_o,
  output logic [AW-1:0] next_word_o
);

  // Limit carries one extra bit so BASE+SPAN at the top of the address map cannot wrap.
  localparam logic [AW:0]   LIMIT      = {1'b0, BASE_ADDR} + {1'b0, SPAN_BYTES};
  localparam logic [AW-1:0] SPAN_WORDS = SPAN_BYTES >> SHIFT;

  logic [AW-1:0] offset;

  assign offset         = awaddr_i - BASE_ADDR;
  assign start_word_o   = offset >> SHIFT;
  assign start_in_win_o = (awaddr_i >= BASE_ADDR) && ({1'b0, awaddr_i} < LIMIT);
  assign word_in_win_o  = word_i < SPAN_WORDS;
  assign next_word_o    = incr_i ? word_i + AW'(1) : word_i;

endmodule

// File: rtl/axi4_burst_write_slave.sv
// AXI4 AW/W/B responder forwarding beats to the image buffer; one burst at a time.
// Optional saturating B-response statistics when AXI_WR_STATS_EN is defined.
//   state   | meaning
//   ST_IDLE | awready high, waiting for a write address
//   ST_DATA | accepting W beats, forwarding or draining them
//   ST_RESP | bvalid high until bready
module axi4_burst_write_slave
  import axi4_slave_pkg::*;
#(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_DATA_WIDTH = 128,
  parameter int                        AXI_ID_WIDTH   = 16,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'hA001_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] SPAN_BYTES     = 32'h0001_0000,
  parameter int                        WADDR_WIDTH    = 12
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_rst,
  input  logic [AXI_ID_WIDTH-1:0]       s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [AXI_ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  output logic                          wr_en,
  output logic [WADDR_WIDTH-1:0]        wr_addr,
  output logic [AXI_DATA_WIDTH-1:0]     wr_data,
  output logic [AXI_DATA_WIDTH/8-1:0]   wr_strb,
  output logic                          wr_last,
`ifdef AXI_WR_STATS_EN
  output logic [31:0]                   stat_bursts,
  output logic [15:0]                   stat_errs,
`endif
  input  logic                          wr_ready
);

  localparam int         BYTES     = AXI_DATA_WIDTH / 8;
  localparam int         SHIFT     = $clog2(BYTES);
  localparam logic [2:0] SIZE_FULL = 3'(SHIFT);

  if ((64'(SPAN_BYTES) >> SHIFT) > (64'(1) << WADDR_WIDTH)) begin : g_param_check
    $error("SPAN_BYTES does not fit in the wr_addr word index");
  end

  wr_state_e                 state_q, state_d;
  logic                      awready_q, bvalid_q;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d, bid_q, bid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      incr_q, incr_d;
  logic [7:0]                len_q, len_d, cnt_q, cnt_d;
  logic [AXI_ADDR_WIDTH-1:0] word_q, word_d;
  logic                      drop_q, drop_d, slverr_q, slverr_d, decerr_q, decerr_d;

  logic [AXI_ADDR_WIDTH-1:0] start_word, next_word;
  logic                      start_in_win, word_in_win;
  logic                      size_bad, beat_drop, beat, last_beat;

  axi4_beat_addr_gen #(
    .AW        (AXI_ADDR_WIDTH),
    .SHIFT     (SHIFT),
    .BASE_ADDR (BASE_ADDR),
    .SPAN_BYTES(SPAN_BYTES)
  ) u_addr_gen (
    .awaddr_i      (s_axi_awaddr),
    .word_i        (word_q),
    .incr_i        (incr_q),
    .start_word_o  (start_word),
    .start_in_win_o(start_in_win),
    .word_in_win_o (word_in_win),
    .next_word_o   (next_word)
  );

  // Rejected bursts and beats past the window top are drained without touching the buffer.
  assign size_bad     = (s_axi_awsize != SIZE_FULL) || s_axi_awburst[1];
  assign beat_drop    = drop_q || !word_in_win;
  assign last_beat    = (cnt_q == len_q);
  assign s_axi_wready = (state_q == ST_DATA) && (beat_drop || wr_ready);
  assign beat         = s_axi_wvalid && s_axi_wready;

  assign wr_en   = beat && !beat_drop;
  assign wr_addr = wr_en ? word_q[WADDR_WIDTH-1:0] : '0;
  assign wr_data = wr_en ? s_axi_wdata : '0;
  assign wr_strb = wr_en ? s_axi_wstrb : '0;
  assign wr_last = wr_en && last_beat;

  assign s_axi_awready = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    incr_d   = incr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    drop_d   = drop_q;
    slverr_d = slverr_q;
    decerr_d = decerr_q;
    case (state_q)
      ST_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          id_d     = s_axi_awid;
          incr_d   = (s_axi_awburst == BURST_INCR);
          len_d    = s_axi_awlen;
          cnt_d    = '0;
          word_d   = start_word;
          slverr_d = size_bad;
          decerr_d = !start_in_win;
          drop_d   = size_bad || !start_in_win;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat) begin
          cnt_d  = cnt_q + 8'd1;
          word_d = next_word;
          if (!drop_q && !word_in_win) decerr_d = 1'b1;
          if (s_axi_wlast != last_beat) slverr_d = 1'b1;
          if (last_beat) begin
            state_d = ST_RESP;
            bid_d   = id_q;
            bresp_d = decerr_d ? RESP_DECERR : (slverr_d ? RESP_SLVERR : RESP_OKAY);
          end
        end
      end
      ST_RESP: begin
        if (s_axi_bready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_rst) begin
      state_q   <= ST_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      id_q      <= '0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      incr_q    <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      drop_q    <= 1'b0;
      slverr_q  <= 1'b0;
      decerr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= (state_d == ST_IDLE);
      bvalid_q  <= (state_d == ST_RESP);
      id_q      <= id_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      incr_q    <= incr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      drop_q    <= drop_d;
      slverr_q  <= slverr_d;
      decerr_q  <= decerr_d;
    end
  end

`ifdef AXI_WR_STATS_EN
  logic        b_hs;
  logic [31:0] stat_bursts_q;
  logic [15:0] stat_errs_q;

  assign b_hs = bvalid_q && s_axi_bready;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_rst) begin
      stat_bursts_q <= '0;
      stat_errs_q   <= '0;
    end else if (b_hs) begin
      if (stat_bursts_q != '1) stat_bursts_q <= stat_bursts_q + 32'd1;
      if (bresp_q != RESP_OKAY && stat_errs_q != '1) stat_errs_q <= stat_errs_q + 16'd1;
    end
  end

  assign stat_bursts = stat_bursts_q;
  assign stat_errs   = stat_errs_q;
`endif

endmodule
